// File: rtl/asi_pkg.sv
// Shared types and constants for the ASI user-port arbiter.
// Holds the arbiter state type and the arbitration mode selectors.
package asi_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } TYPE_ARB;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

endpackage

// File: rtl/asi_rr_pick.sv
// Cyclic first-requester search starting at a given pointer.
// A zero pointer turns it into a plain lowest-index priority picker.
module asi_rr_pick
    import asi_pkg::*;
#(
    parameter int NCH = 2,
    parameter int GW  = 1
) (
    input  logic [NCH-1:0] req_i,
    input  logic [GW-1:0]  start_i,
    output logic           valid_o,
    output logic [GW-1:0]  idx_o
);

    int cand;

    // Scan from the farthest candidate back to the start so the nearest requester wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        for (int k = NCH - 1; k >= 0; k--) begin
            cand = int'(start_i) + k;
            if (cand >= NCH) begin
                cand = cand - NCH;
            end
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = GW'(cand);
            end
        end
    end

endmodule

// File: rtl/asi_arb.sv
// Burst arbiter multiplexing NCH request channels onto one user port.
// Grants are held for a whole burst and released on the last beat or at the beat limit.
module asi_arb
    import asi_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int AXI_AW    = 40,
    parameter int ARB_MODE  = ARB_FIXED,
    parameter int MAX_BEATS = 256,
    localparam int GW       = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int CW       = $clog2(MAX_BEATS + 1)
) (
    input  logic                  usr_clk,
    input  logic                  usr_reset_n,
    input  logic [NCH-1:0]        ch_req,
    input  logic [NCH-1:0]        ch_beat,
    input  logic [NCH-1:0]        ch_last,
    input  logic [NCH-1:0]        ch_we,
    input  logic [NCH*AXI_AW-1:0] ch_addr,
    output logic [AXI_AW-1:0]     m_addr,
    output logic                  m_we,
    output logic                  m_re,
    output logic [NCH-1:0]        gnt,
    output logic [GW-1:0]         gnt_idx,
    output logic                  busy,
    output logic                  ovf_err
);

    TYPE_ARB           state_q;
    logic [NCH-1:0]    gnt_q;
    logic [GW-1:0]     gnt_idx_q;
    logic [GW-1:0]     rr_ptr_q;
    logic [CW-1:0]     beat_cnt_q;
    logic              ovf_q;
    logic              armed_q;

    logic              beat_hit;
    logic              last_hit;
    logic              limit_hit;
    logic              rearb;
    logic              pick_valid;
    logic [GW-1:0]     pick_idx;
    logic [GW-1:0]     pick_start;
    logic [GW-1:0]     ptr_next;
    logic [AXI_AW-1:0] addr_arr [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_addr
        assign addr_arr[i] = ch_addr[i*AXI_AW +: AXI_AW];
    end

    asi_rr_pick #(
        .NCH (NCH),
        .GW  (GW)
    ) u_pick (
        .req_i   (ch_req),
        .start_i (pick_start),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // Only the granted channel's beat counts; the limit beat releases like a last beat.
    always_comb begin
        beat_hit   = (state_q == ARB_GRANT) && ch_beat[gnt_idx_q];
        last_hit   = beat_hit && ch_last[gnt_idx_q];
        limit_hit  = beat_hit && !ch_last[gnt_idx_q] && (beat_cnt_q == CW'(MAX_BEATS - 1));
        rearb      = armed_q && ((state_q == ARB_IDLE) || last_hit || limit_hit);
        pick_start = (ARB_MODE == ARB_RR) ? rr_ptr_q : '0;
        ptr_next   = (pick_idx == GW'(NCH - 1)) ? '0 : pick_idx + 1'b1;
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign busy    = (state_q == ARB_GRANT);
    assign ovf_err = ovf_q;
    assign m_we    = beat_hit & ch_we[gnt_idx_q];
    assign m_re    = beat_hit & ~ch_we[gnt_idx_q];
    assign m_addr  = addr_arr[gnt_idx_q];

    // armed_q holds off arbitration for the first edge after reset release.
    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            state_q    <= ARB_IDLE;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            ovf_q      <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            ovf_q   <= limit_hit;
            if (rearb) begin
                beat_cnt_q <= '0;
                if (pick_valid) begin
                    state_q   <= ARB_GRANT;
                    gnt_q     <= NCH'(1) << pick_idx;
                    gnt_idx_q <= pick_idx;
                    if (ARB_MODE == ARB_RR) begin
                        rr_ptr_q <= ptr_next;
                    end
                end else begin
                    state_q   <= ARB_IDLE;
                    gnt_q     <= '0;
                    gnt_idx_q <= '0;
                end
            end else if (beat_hit && (beat_cnt_q != CW'(MAX_BEATS))) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: doc/asi_arb.md
ASI_ARB -- requirements
Module: asi_arb

Interface
REQ-001 SHALL have parameter NCH, default 2, number of request channels (1..16).
REQ-002 SHALL have parameter AXI_AW, default 40, address width.
REQ-003 SHALL have parameter ARB_MODE, default 0, selecting the arbitration mode: 0 fixed priority (lowest index wins), 1 round-robin.
REQ-004 SHALL have parameter MAX_BEATS, default 256, the beat limit per grant.
REQ-005 SHALL derive GW = max(1, $clog2(NCH)) and CW = $clog2(MAX_BEATS+1).
REQ-006 SHALL have port usr_clk, input, 1, the only clock.
REQ-007 SHALL have port usr_reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port ch_req, input, NCH, channel has a pending burst (queue head valid).
REQ-009 SHALL have port ch_beat, input, NCH, channel issues one beat this cycle.
REQ-010 SHALL have port ch_last, input, NCH, qualifies ch_beat as the last beat of the burst.
REQ-011 SHALL have port ch_we, input, NCH, 1 = write burst, 0 = read burst.
REQ-012 SHALL have port ch_addr, input, NCH*AXI_AW, per-channel beat address, where channel i occupies bits [i*AXI_AW +: AXI_AW].
REQ-013 SHALL have port m_addr, output, AXI_AW, user-port address.
REQ-014 SHALL have port m_we, output, 1, user-port write strobe.
REQ-015 SHALL have port m_re, output, 1, user-port read strobe.
REQ-016 SHALL have port gnt, output, NCH, one-hot registered grant.
REQ-017 SHALL have port gnt_idx, output, GW, encoded grant index.
REQ-018 SHALL have port busy, output, 1, high in GRANT.
REQ-019 SHALL have port ovf_err, output, 1, one-cycle pulse on a forced release.

Function
REQ-020 SHALL implement states ARB_IDLE and ARB_GRANT.
REQ-021 In ARB_IDLE with any ch_req high, SHALL pick a winner, load gnt/gnt_idx and enter ARB_GRANT on the next edge, giving 1 cycle from request to grant.
REQ-022 In ARB_MODE 0, SHALL choose the winner as the lowest-index requester.
REQ-023 In ARB_MODE 1, SHALL choose the first requester at or after rr_ptr, searching cyclically.
REQ-024 In ARB_MODE 1, SHALL load rr_ptr with (winner+1) mod NCH on every grant.
REQ-025 In ARB_GRANT, SHALL honour ch_beat only for the granted channel; ch_beat, ch_last and ch_we of other channels SHALL be ignored.
REQ-026 SHALL drive m_we = busy & ch_beat[g] & ch_we[g], combinationally.
REQ-027 SHALL drive m_re = busy & ch_beat[g] & ~ch_we[g], combinationally.
REQ-028 SHALL drive m_addr = ch_addr[gnt_idx] in every state.
REQ-029 ch_last without ch_beat SHALL have no effect.
REQ-030 On ch_beat[g] & ch_last[g], SHALL re-arbitrate in that cycle on that cycle's ch_req (the finishing channel included): if there is a winner, the new gnt is valid on the next edge with zero idle cycles; otherwise the block SHALL go to ARB_IDLE with gnt = 0.
REQ-031 beat_cnt SHALL clear on every grant, increment on each honoured beat, and saturate at MAX_BEATS.
REQ-032 On the MAX_BEATS-th honoured beat without ch_last, SHALL release the grant exactly as for a last beat and pulse ovf_err the following cycle.
REQ-033 With NCH = 1, SHALL behave identically in both modes, with rr_ptr held at 0.
REQ-034 gnt SHALL always be one-hot or zero.
REQ-035 gnt_idx SHALL equal the position of the gnt bit, or 0 when gnt = 0.

Reset
REQ-036 On usr_reset_n low (asynchronous, including mid-burst), SHALL force the state to ARB_IDLE and set gnt, gnt_idx, rr_ptr, beat_cnt, busy and ovf_err to 0; m_we and m_re SHALL then read 0.
REQ-037 The first grant SHALL be possible on the second rising edge after reset deassertion.

Structure
REQ-038 Package asi_pkg SHALL hold the TYPE_ARB state enum and the ARB_FIXED = 0 / ARB_RR = 1 constants.
REQ-039 A combinational sub-module asi_rr_pick (inputs: request vector and start pointer; outputs: valid and index) SHALL be instantiated once and serve both modes, with the pointer tied to 0 in mode 0.

Verification
REQ-040 NCH=2, mode 0: ch_req = 2'b11 with 4-beat bursts on both channels -> channel 0 is granted repeatedly while its ch_req stays high; channel 1 is granted in the cycle after channel 0's last beat once ch_req[0] drops.
REQ-041 NCH=4, mode 1: all channels requesting continuously with 2-beat bursts -> grant order 0,1,2,3,0, with no idle cycle between bursts.
REQ-042 NCH=2: ch_beat[1] pulses while gnt = 2'b01 -> m_we = m_re = 0 for those beats and beat_cnt unchanged.
REQ-043 MAX_BEATS=8: the granted channel issues 10 beats with no ch_last -> release after beat 8, a single ovf_err pulse, and re-arbitration on the next edge.
REQ-044 usr_reset_n is asserted in the middle of beat 3 of 5 -> gnt = 0 and m_we = m_re = 0 immediately; after release, ch_req[2] is granted 1 cycle later in mode 1 with rr_ptr starting at 0.
